// File: rtl/stepper_phase_driver_if.sv
// Command handshake bundle for stepper_phase_driver: the sender drives valid/lines/dir
// and the driver returns ready.
interface stepper_phase_driver_if #(
    parameter int unsigned CMD_WIDTH = 8
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CMD_WIDTH-1:0] cmd_lines;
    logic                 cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_lines,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_lines,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_phase_driver.sv
// Two-phase Gray-coded stepper drive: feeds cmd_lines lines (two steps per line) at one step
// per STEP_PERIOD clocks. Optional line_tick output under STEPPER_PHASE_DRIVER_LINE_TICK_EN.
module stepper_phase_driver #(
    parameter int unsigned STEP_PERIOD = 1000,
    parameter int unsigned CMD_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    stepper_phase_driver_if.slave        cmd,
    input  logic                         abort,
    output logic                         motor_phase_a,
    output logic                         motor_phase_b,
    output logic                         busy,
    output logic                         done_tick
`ifdef STEPPER_PHASE_DRIVER_LINE_TICK_EN
    ,
    output logic                         line_tick
`endif
);

    localparam int unsigned TW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(STEP_PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CMD_WIDTH:0] steps_q, steps_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               line_q, line_d;

    // Gray step on {a, b}: forward 00->01->11->10, reverse is the inverse walk.
    function automatic logic [1:0] next_phase(input logic [1:0] p, input logic rev);
        return rev ? {~p[0], p[1]} : {p[0], ~p[1]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            phase_q <= 2'b00;
            timer_q <= '0;
            steps_q <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        line_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    dir_d   = cmd.cmd_dir;
                    steps_d = {cmd.cmd_lines, 1'b0};
                    timer_d = '0;
                    if (cmd.cmd_lines != '0) begin
                        state_d = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    // A step due on this same cycle is dropped.
                    state_d = StDone;
                    done_d  = 1'b1;
                    timer_d = '0;
                    steps_d = '0;
                end else if (timer_q == TimerLast) begin
                    timer_d = '0;
                    phase_d = next_phase(phase_q, dir_q);
                    steps_d = steps_q - 1'b1;
                    // Odd count before the step means this step closes a line.
                    line_d  = steps_q[0];
                    if (steps_q == (CMD_WIDTH + 1)'(1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cmd.cmd_ready  = (state_q == StIdle);
    assign busy           = (state_q == StRun);
    assign done_tick      = done_q;
    assign motor_phase_a  = phase_q[1];
    assign motor_phase_b  = phase_q[0];

`ifdef STEPPER_PHASE_DRIVER_LINE_TICK_EN
    assign line_tick = line_q;
`else
    logic unused_line;
    assign unused_line = line_q;
`endif

endmodule
